// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte stream
// into big-endian 16-bit words for the instruction ROM and holds the CPU in reset until verified.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256,
  parameter int          TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        rom_wen,
  output logic [15:0] rom_waddr,
  output logic [15:0] rom_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  state_t          state;
  logic [15:0]     len;
  logic [15:0]     index;
  logic [7:0]      hiByte;
  logic [7:0]      chkSum;
  logic [TW-1:0]   toCnt;

  logic            accept;
  logic            startLoad;
  logic [15:0]     lenFull;

  assign in_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);
  assign accept    = in_valid & in_ready;
  assign startLoad = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign lenFull   = {len[15:8], in_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      rom_wen      <= 1'b0;
      rom_waddr    <= 16'h0000;
      rom_wdata    <= 16'h0000;
      words_loaded <= 16'h0000;
      len          <= 16'h0000;
      index        <= 16'h0000;
      hiByte       <= 8'h00;
      chkSum       <= 8'h00;
      toCnt        <= '0;
    end else begin
      rom_wen <= 1'b0;

      // Every frame byte except the checksum byte itself folds into the running XOR.
      if (accept && state != CHECK)
        chkSum <= chkSum ^ in_data;

      case (state)
        LEN_HI: if (accept) begin
          len[15:8] <= in_data;
          state     <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          len[7:0] <= in_data;
          if (lenFull == 16'h0000 || {1'b0, lenFull} > 17'(MAX_WORDS)) begin
            state <= ERROR;
            err   <= 1'b1;
          end else begin
            state <= DATA_HI;
          end
        end
        DATA_HI: if (accept) begin
          hiByte <= in_data;
          state  <= DATA_LO;
        end
        DATA_LO: if (accept) begin
          rom_wen      <= 1'b1;
          rom_wdata    <= {hiByte, in_data};
          rom_waddr    <= BASE_ADDR + (index << 1);
          index        <= index + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          state        <= (index == len - 16'd1) ? CHECK : DATA_HI;
        end
        CHECK: if (accept) begin
          if (in_data == chkSum) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= ERROR;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase

      // Idle-gap watchdog; an accepted byte in the same cycle always wins.
      if (in_ready) begin
        if (accept) begin
          toCnt <= '0;
        end else if (toCnt == TW'(TIMEOUT - 1)) begin
          state <= ERROR;
          err   <= 1'b1;
        end else begin
          toCnt <= toCnt + 1'b1;
        end
      end

      if (startLoad) begin
        state        <= LEN_HI;
        cpu_rst      <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        chkSum       <= 8'h00;
        index        <= 16'h0000;
        words_loaded <= 16'h0000;
        toCnt        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/length/timeout errors, reset and reload.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        rom_wen;
  logic [15:0] rom_waddr;
  logic [15:0] rom_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rom_wen(rom_wen), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int checkCnt = 0;
  logic [31:0] wq[$];
  logic [7:0]  frame[$];

  always @(negedge clk) if (rom_wen) wq.push_back({rom_waddr, rom_wdata});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkCnt++;
      $display("FAIL send_byte: in_ready=%0b required 1 for byte %h", in_ready, b);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int gap);
    foreach (frame[i]) sendByte(frame[i], gap);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkCnt++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %0b want 1", cpu_rst); else passCnt++;
    checkCnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passCnt++;
    checkCnt++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else passCnt++;
    checkCnt++; if (rom_wen !== 1'b0) $display("FAIL reset_wen: got %0b want 0", rom_wen); else passCnt++;
    checkCnt++; if ({rom_waddr, rom_wdata} !== 32'h0) $display("FAIL reset_rom: got %h want 00000000", {rom_waddr, rom_wdata}); else passCnt++;
    checkCnt++; if (words_loaded !== 16'h0) $display("FAIL reset_words: got %h want 0000", words_loaded); else passCnt++;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", in_ready); else passCnt++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL idle_ready: got %0b want 0", in_ready); else passCnt++;
    $display("reset: checks so far %0d/%0d", passCnt, checkCnt);
  endtask

  task automatic test_good_load();
    wq.delete();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    sendFrame(0);
    repeat (2) @(negedge clk);
    checkCnt++; if (wq.size() !== 2) $display("FAIL good_wcount: got %0d want 2", wq.size()); else passCnt++;
    if (wq.size() == 2) begin
      checkCnt++; if (wq[0] !== 32'h0000_1234) $display("FAIL good_w0: got %h want 00001234", wq[0]); else passCnt++;
      checkCnt++; if (wq[1] !== 32'h0002_ABCD) $display("FAIL good_w1: got %h want 0002abcd", wq[1]); else passCnt++;
    end
    checkCnt++; if ({done, cpu_rst, err} !== 3'b100) $display("FAIL good_status: done/cpu_rst/err got %b want 100", {done, cpu_rst, err}); else passCnt++;
    checkCnt++; if (words_loaded !== 16'd2) $display("FAIL good_words: got %0d want 2", words_loaded); else passCnt++;
    checkCnt++; if (in_ready !== 1'b0) $display("FAIL good_ready: got %0b want 0", in_ready); else passCnt++;
    $display("good_load: writes=%0d done=%0b", wq.size(), done);
  endtask

  task automatic test_bad_checksum();
    wq.delete();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    sendFrame(0);
    @(negedge clk);
    checkCnt++; if (wq.size() !== 2) $display("FAIL badchk_wcount: got %0d want 2", wq.size()); else passCnt++;
    checkCnt++; if ({done, cpu_rst, err} !== 3'b011) $display("FAIL badchk_status: done/cpu_rst/err got %b want 011", {done, cpu_rst, err}); else passCnt++;
    pulseStart();
    checkCnt++; if (err !== 1'b0) $display("FAIL badchk_errclr: got %0b want 0", err); else passCnt++;
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    sendFrame(0);
    checkCnt++; if ({done, cpu_rst, err} !== 3'b100) $display("FAIL badchk_retry: done/cpu_rst/err got %b want 100", {done, cpu_rst, err}); else passCnt++;
    $display("bad_checksum: err then retry done=%0b", done);
  endtask

  task automatic test_len_errors();
    wq.delete();
    pulseStart();
    frame = {8'h00, 8'h00};
    sendFrame(0);
    checkCnt++; if ({err, in_ready} !== 2'b10) $display("FAIL len0: err/in_ready got %b want 10", {err, in_ready}); else passCnt++;
    pulseStart();
    frame = {8'h01, 8'h01};
    sendFrame(0);
    repeat (2) @(negedge clk);
    checkCnt++; if ({err, done} !== 2'b10) $display("FAIL len257: err/done got %b want 10", {err, done}); else passCnt++;
    checkCnt++; if (wq.size() !== 0) $display("FAIL len_nowrite: got %0d writes want 0", wq.size()); else passCnt++;
    $display("len_errors: err=%0b writes=%0d", err, wq.size());
  endtask

  task automatic test_max_len();
    logic [7:0] x;
    logic [7:0] h;
    wq.delete();
    frame = {8'h01, 8'h00};
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      h = 8'(i);
      frame.push_back(h);
      frame.push_back(h ^ 8'h5A);
      x = x ^ h ^ (h ^ 8'h5A);
    end
    frame.push_back(x);
    pulseStart();
    sendFrame(0);
    @(negedge clk);
    checkCnt++; if (wq.size() !== 256) $display("FAIL max_wcount: got %0d want 256", wq.size()); else passCnt++;
    if (wq.size() == 256) begin
      checkCnt++; if (wq[255] !== 32'h01FE_FFA5) $display("FAIL max_wlast: got %h want 01feffa5", wq[255]); else passCnt++;
    end
    checkCnt++; if ({done, err, words_loaded} !== {2'b10, 16'd256}) $display("FAIL max_status: done=%0b err=%0b words=%0d want 1 0 256", done, err, words_loaded); else passCnt++;
    $display("max_len: writes=%0d done=%0b", wq.size(), done);
  endtask

  task automatic test_throttle();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    sendFrame(7);
    checkCnt++; if ({done, err} !== 2'b10) $display("FAIL throttle: done/err got %b want 10", {done, err}); else passCnt++;
    $display("throttle: done=%0b err=%0b", done, err);
  endtask

  task automatic test_timeout();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12};
    sendFrame(0);
    repeat (7) @(negedge clk);
    checkCnt++; if (err !== 1'b0) $display("FAIL timeout_early: err got %0b want 0 after 7 idle", err); else passCnt++;
    @(negedge clk);
    checkCnt++; if ({err, in_ready, done} !== 3'b100) $display("FAIL timeout: err/in_ready/done got %b want 100", {err, in_ready, done}); else passCnt++;
    checkCnt++; if (words_loaded !== 16'd0) $display("FAIL timeout_words: got %0d want 0", words_loaded); else passCnt++;
    $display("timeout: err=%0b", err);
  endtask

  task automatic test_reset_mid();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    sendFrame(0);
    wq.delete();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkCnt++; if (words_loaded !== 16'd0) $display("FAIL rstmid_words: got %0d want 0", words_loaded); else passCnt++;
    checkCnt++; if ({cpu_rst, in_ready, done, err} !== 4'b1000) $display("FAIL rstmid_status: cpu_rst/in_ready/done/err got %b want 1000", {cpu_rst, in_ready, done, err}); else passCnt++;
    in_valid = 1'b1;
    in_data  = 8'hCD;
    repeat (3) @(negedge clk);
    in_data  = 8'h42;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checkCnt++; if (wq.size() !== 0 || in_ready !== 1'b0) $display("FAIL rstmid_ignored: writes=%0d in_ready=%0b want 0 0", wq.size(), in_ready); else passCnt++;
    $display("reset_mid: words=%0d writes=%0d", words_loaded, wq.size());
  endtask

  task automatic test_reload();
    pulseStart();
    frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    sendFrame(0);
    checkCnt++; if (done !== 1'b1) $display("FAIL reload_first: done got %0b want 1", done); else passCnt++;
    wq.delete();
    pulseStart();
    checkCnt++; if ({cpu_rst, done, in_ready} !== 3'b101) $display("FAIL reload_start: cpu_rst/done/in_ready got %b want 101", {cpu_rst, done, in_ready}); else passCnt++;
    frame = {8'h00, 8'h01};
    sendFrame(0);
    pulseStart();
    frame = {8'hFF, 8'hEE, 8'h10};
    sendFrame(0);
    @(negedge clk);
    checkCnt++; if (wq.size() !== 1) $display("FAIL reload_wcount: got %0d want 1", wq.size()); else passCnt++;
    if (wq.size() == 1) begin
      checkCnt++; if (wq[0] !== 32'h0000_FFEE) $display("FAIL reload_w0: got %h want 0000ffee", wq[0]); else passCnt++;
    end
    checkCnt++; if ({done, cpu_rst, err, words_loaded} !== {3'b100, 16'd1}) $display("FAIL reload_status: done=%0b cpu_rst=%0b err=%0b words=%0d want 1 0 0 1", done, cpu_rst, err, words_loaded); else passCnt++;
    $display("reload: writes=%0d done=%0b", wq.size(), done);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_len_errors();
    test_max_len();
    test_throttle();
    test_timeout();
    test_reset_mid();
    test_reload();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU's instruction ROM.
- Receives a framed byte stream over a valid/ready handshake.
- Assembles big-endian 16-bit instruction words and writes them into the ROM write port at byte addresses (PC steps by 2).
- Holds the CPU in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
BASE_ADDR, 16'h0000, ROM byte address of the first loaded word
MAX_WORDS, 256, largest accepted word count; a larger count is a framing error
TIMEOUT, 65535, idle cycles allowed between accepted bytes mid-frame before aborting

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  begin a load (honoured only in IDLE, DONE or ERROR)
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
rom_wen  output  1  ROM write strobe, one-cycle pulse per word
rom_waddr  output  16  ROM byte address of the write
rom_wdata  output  16  instruction word to write
cpu_rst  output  1  active-high reset to the CPU
done  output  1  image loaded and verified; CPU running
err  output  1  load aborted (bad length, checksum, or timeout)
words_loaded  output  16  number of words written in the current or last load

Behaviour:
- Reset (rst==0 at posedge), values on the next edge:
  - state IDLE, cpu_rst=1, done=0, err=0, rom_wen=0.
  - rom_waddr=0, rom_wdata=0, words_loaded=0; checksum, length, index and timeout registers all 0.
- A reset mid-load aborts immediately. No further writes occur.
- Frame format: LEN_HI, LEN_LO, then 2*N data bytes (hi byte first per word), then CHK. N={LEN_HI,LEN_LO}.
  - CHK = XOR of every preceding frame byte, length bytes included.
- Byte accepted on any posedge where in_valid & in_ready.
- in_ready is a Moore output: 1 exactly in states LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 otherwise.
- States:
  - IDLE: cpu_rst=1. start -> LEN_HI. On entry to LEN_HI clear checksum, index, words_loaded and timeout.
  - LEN_HI: accept -> store len[15:8] -> LEN_LO.
  - LEN_LO: accept -> store len[7:0].
    - len==0 or len>MAX_WORDS -> ERROR.
    - Else -> DATA_HI.
  - DATA_HI: accept -> latch hi byte -> DATA_LO.
  - DATA_LO: accept -> next cycle drives rom_wen=1 for exactly one cycle, with:
    - rom_wdata={hi,lo}
    - rom_waddr=BASE_ADDR+2*index, 16-bit wrap-around
    - index and words_loaded increment
    - If the word just written is word N-1 -> CHECK, else -> DATA_HI.
    - The write pulse overlaps the next state; no stall.
  - CHECK: accept -> compare byte with running XOR. Equal -> DONE, else -> ERROR.
  - DONE: done=1, cpu_rst=0, err=0. start -> cpu_rst=1, done=0, -> LEN_HI (reload).
  - ERROR: err=1, cpu_rst=1, done=0. start -> err=0 -> LEN_HI. Words already written are left in ROM.
- start is ignored in LEN_HI..CHECK.
- Timeout counter, in states LEN_HI..CHECK only:
  - Cleared on every accepted byte and on entry to LEN_HI.
  - Otherwise increments each cycle.
  - Reaching TIMEOUT -> ERROR on the next edge.
  - A byte accepted on the same cycle wins, counter clears.
- Checksum register updates with every accepted byte except CHK itself.
- Outputs are all registered except in_ready, which is decoded from the state register.
- cpu_rst leaves 1 only in the cycle after the DONE transition.

Test Plan:
- Good load: start, bytes 00 02 12 34 AB CD 42 with in_valid held high. Required:
  - rom_wen pulses exactly twice: addr 0x0000 data 0x1234, then addr 0x0002 data 0xABCD.
  - Then done=1, cpu_rst=0, err=0, words_loaded=2.
- Bad checksum: same frame with CHK=0x43.
  - Both writes occur, then err=1, done=0, cpu_rst=1.
  - A further start followed by the good frame ends with done=1.
- Length errors, each -> err=1 after LEN_LO, no rom_wen pulse:
  - Frame 00 00 (len=0).
  - With MAX_WORDS=256, frame 01 01 (len=257).
- Throttling and timeout, with TIMEOUT=8:
  - Good frame with in_valid deasserted 7 cycles between bytes -> done=1.
  - Stop after byte 12 for 8 cycles -> err=1, in_ready=0, words_loaded=0.
- Reset mid-load: rst=0 for one cycle after byte AB of the good frame. Required:
  - Next edge: state IDLE, words_loaded=0, cpu_rst=1, in_ready=0.
  - Subsequent bytes ignored, no rom_wen.
- Reload from DONE and start ignored mid-frame:
  - After a good load, start -> cpu_rst=1, done=0.
  - A start pulse during DATA_HI is ignored.
  - New frame 00 01 FF EE 10 -> one write addr 0x0000 data 0xFFEE, done=1.
